// File: rtl/bad_point_scheduler_if.sv
// BRAM read port between the bad-point scheduler (master) and the LUT BRAM (slave).
// Read data is valid one cycle after lut_rd_en.
interface bad_point_scheduler_if #(
  parameter int BAD_POINT_BIT = 7
);
  logic                     lut_rd_en;
  logic [BAD_POINT_BIT-1:0] lut_raddr;
  logic [31:0]              lut_rdata;

  modport master (output lut_rd_en, output lut_raddr, input lut_rdata);
  modport slave  (input lut_rd_en, input lut_raddr, output lut_rdata);
endinterface

// File: rtl/bad_point_scheduler.sv
// Walks the sorted manual bad-point list alongside the pixel stream and flags matching pixels.
// Keeps a 2-entry prefetch queue in front of the BRAM so a match can be popped every pixel.
module bad_point_scheduler #(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 10,
  parameter int BAD_POINT_MUN = 128,
  parameter int BAD_POINT_BIT = $clog2(BAD_POINT_MUN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH_BITS-1:0]    img_width,
  input  logic [HEIGHT_BITS-1:0]   img_height,
  input  logic [BAD_POINT_BIT-1:0] bad_point_num,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  bad_point_scheduler_if.master    lut,
  output logic                     pix_valid_o,
  output logic                     bad_flag_o,
  output logic [WIDTH_BITS-1:0]    col_o,
  output logic [HEIGHT_BITS-1:0]   row_o,
  output logic                     frame_done,
  output logic                     list_err
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                   state, state_next;
  logic [WIDTH_BITS-1:0]    width_q, col;
  logic [HEIGHT_BITS-1:0]   height_q, row;
  logic [BAD_POINT_BIT-1:0] num_q, fetched;
  logic [WIDTH_BITS-1:0]    q_col0, q_col1;
  logic [HEIGHT_BITS-1:0]   q_row0, q_row1;
  logic [1:0]               q_count;
  logic                     in_flight;

  logic                     pix_run, has_head, match, behind, pop, last_pix;
  logic                     rd_en, prime_done;
  logic [2:0]               occ;
  logic [WIDTH_BITS-1:0]    new_col;
  logic [HEIGHT_BITS-1:0]   new_row;
  logic                     unused_rdata;

  assign new_col      = lut.lut_rdata[WIDTH_BITS+15:16];
  assign new_row      = lut.lut_rdata[HEIGHT_BITS-1:0];
  assign unused_rdata = ^{lut.lut_rdata[31:WIDTH_BITS+16], lut.lut_rdata[15:HEIGHT_BITS]};

  // Occupancy counts the pop of this pixel so the queue refills in time for back-to-back matches.
  always_comb begin
    pix_run    = pix_valid && (state == RUN) && !frame_start;
    has_head   = (q_count != 2'd0);
    match      = pix_run && has_head && (q_col0 == col) && (q_row0 == row);
    behind     = pix_run && has_head &&
                 ((q_row0 < row) || ((q_row0 == row) && (q_col0 < col)));
    pop        = match || behind;
    last_pix   = pix_run && (col == width_q - WIDTH_BITS'(1)) &&
                 (row == height_q - HEIGHT_BITS'(1));
    occ        = {1'b0, q_count} + {2'b00, in_flight} - {2'b00, pop};
    rd_en      = !rst && !frame_start && ((state == PRIME) || (state == RUN)) &&
                 (fetched < num_q) && (occ < 3'd2);
    prime_done = (fetched == num_q) ||
                 (({1'b0, q_count} + {2'b00, in_flight}) == 3'd2);
  end

  assign lut.lut_rd_en = rd_en;
  assign lut.lut_raddr = fetched;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = IDLE;
      PRIME:   if (prime_done) state_next = RUN;
      RUN:     if (last_pix) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (frame_start) state_next = PRIME;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      num_q       <= '0;
      col         <= '0;
      row         <= '0;
      fetched     <= '0;
      q_col0      <= '0;
      q_row0      <= '0;
      q_col1      <= '0;
      q_row1      <= '0;
      q_count     <= '0;
      in_flight   <= 1'b0;
      pix_valid_o <= 1'b0;
      bad_flag_o  <= 1'b0;
      col_o       <= '0;
      row_o       <= '0;
      frame_done  <= 1'b0;
      list_err    <= 1'b0;
    end else begin
      state       <= state_next;
      in_flight   <= rd_en;
      pix_valid_o <= pix_valid;
      bad_flag_o  <= match;
      col_o       <= col;
      row_o       <= row;
      frame_done  <= last_pix;
      if (frame_start) begin
        width_q  <= img_width;
        height_q <= img_height;
        num_q    <= bad_point_num;
        col      <= '0;
        row      <= '0;
        fetched  <= '0;
        q_count  <= '0;
        list_err <= 1'b0;
      end else begin
        if (rd_en) fetched <= fetched + BAD_POINT_BIT'(1);
        if ((pix_valid && (state != RUN)) || behind) list_err <= 1'b1;
        if (pix_run) begin
          if (last_pix) begin
            col <= '0;
            row <= '0;
          end else if (col == width_q - WIDTH_BITS'(1)) begin
            col <= '0;
            row <= row + HEIGHT_BITS'(1);
          end else begin
            col <= col + WIDTH_BITS'(1);
          end
        end
        // Occupancy plus reads in flight never exceeds 2, so a push never lands on a full queue.
        unique case ({in_flight, pop})
          2'b10: begin
            if (q_count == 2'd0) begin
              q_col0 <= new_col;
              q_row0 <= new_row;
            end else begin
              q_col1 <= new_col;
              q_row1 <= new_row;
            end
            q_count <= q_count + 2'd1;
          end
          2'b01: begin
            q_col0  <= q_col1;
            q_row0  <= q_row1;
            q_count <= q_count - 2'd1;
          end
          2'b11: begin
            if (q_count == 2'd1) begin
              q_col0 <= new_col;
              q_row0 <= new_row;
            end else begin
              q_col0 <= q_col1;
              q_row0 <= q_row1;
              q_col1 <= new_col;
              q_row1 <= new_row;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
